// File: rtl/sd_arb_pkg.sv
// Shared constants and helpers for the SD sector-port arbiter.
// State encodings are plain constants so legacy tools can compare them directly.
package sd_arb_pkg;

  localparam int unsigned SD_LBA_W     = 32;
  localparam int unsigned SECTOR_BYTES = 512;

  localparam logic [2:0] ST_SYNC  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_XFER  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Modulo-n add for base < n and off <= n; wraps explicitly so non-power-of-2 n works.
  function automatic int unsigned rr_add(input int unsigned base, input int unsigned off,
                                         input int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/sd_sector_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping modulo NREQ.
module rr_pick
  import sd_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic                    any_o,
  output logic [$clog2(NREQ)-1:0] winner_o
);

  localparam int unsigned IW = $clog2(NREQ);

  int unsigned idx_c;

  // Scan farthest-first so the nearest requester to the pointer overwrites last and wins.
  always_comb begin
    any_o    = 1'b0;
    winner_o = '0;
    idx_c    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx_c = rr_add(32'(ptr_i), NREQ - 1 - k, NREQ);
      if (req_i[IW'(idx_c)]) begin
        any_o    = 1'b1;
        winner_o = IW'(idx_c);
      end
    end
  end

endmodule

// File: rtl/sd_sector_arbiter.sv
// Round-robin arbiter sharing the single hps_io SD sector port between NREQ block requesters.
// One sector transaction at a time; owner/busy let the top level mux the sector buffer.
module sd_sector_arbiter
  import sd_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned LBA_W   = SD_LBA_W,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_we,
  input  logic [NREQ*LBA_W-1:0]   req_lba,
  output logic [NREQ-1:0]         req_grant,
  output logic [NREQ-1:0]         req_done,
  output logic                    req_err,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  output logic [LBA_W-1:0]        sd_lba,
  output logic                    sd_rd,
  output logic                    sd_wr,
  input  logic                    sd_ack
);

  localparam int unsigned OW     = $clog2(NREQ);
  localparam int unsigned TCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              ack_q;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     rr_q, rr_d;
  logic [LBA_W-1:0]  lba_q, lba_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;

  logic              any_c;
  logic [OW-1:0]     win_c;
  logic [LBA_W-1:0]  lba_sel_c;
  logic              ack_fall_c;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req_i    (req_valid),
    .ptr_i    (rr_q),
    .any_o    (any_c),
    .winner_o (win_c)
  );

  assign ack_fall_c = ack_q & ~sd_ack;

  always_comb begin
    lba_sel_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_c == OW'(i)) lba_sel_c = req_lba[i*LBA_W +: LBA_W];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    err_d   = 1'b0;
    owner_d = owner_q;
    rr_d    = rr_q;
    lba_d   = lba_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    tcnt_d  = tcnt_q;

    case (state_q)
      ST_SYNC: begin
        if (!sd_ack) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (any_c) begin
          state_d = ST_ISSUE;
          owner_d = win_c;
          rr_d    = OW'(rr_add(32'(win_c), 1, NREQ));
          grant_d = NREQ'(1) << win_c;
          lba_d   = lba_sel_c;
          rd_d    = ~req_we[win_c];
          wr_d    = req_we[win_c];
          tcnt_d  = '0;
        end
      end
      ST_ISSUE: begin
        if (sd_ack) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = ST_XFER;
        end else if ((TIMEOUT != 0) && (tcnt_q == TCNT_LAST)) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          done_d  = grant_q;
          err_d   = 1'b1;
          grant_d = '0;
          state_d = ST_SYNC;
        end else if (tcnt_q != '1) begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      ST_XFER: begin
        if (ack_fall_c) begin
          done_d  = grant_q;
          grant_d = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        grant_d = '0;
        state_d = ST_SYNC;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= ST_SYNC;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b1;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ack_q   <= 1'b0;
      owner_q <= '0;
      rr_q    <= '0;
      lba_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ack_q   <= sd_ack;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      lba_q   <= lba_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign req_grant = grant_q;
  assign req_done  = done_q;
  assign req_err   = err_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign sd_lba    = lba_q;
  assign sd_rd     = rd_q;
  assign sd_wr     = wr_q;

  a_rd_wr_excl: assert property (@(posedge clk_sys) disable iff (reset) !(rd_q && wr_q));
  a_grant_1hot: assert property (@(posedge clk_sys) disable iff (reset) $onehot0(grant_q));

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Scoreboard bench for sd_sector_arbiter (NREQ=2, LBA_W=32, TIMEOUT=16).
module tb_sd_sector_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [63:0] req_lba;
  logic [1:0]  req_grant;
  logic [1:0]  req_done;
  logic        req_err;
  logic [0:0]  owner;
  logic        busy;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;

  typedef struct {
    int          idx;
    bit          we;
    logic [31:0] lba;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  sd_sector_arbiter #(.NREQ(2), .LBA_W(32), .TIMEOUT(16)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_lba   (req_lba),
    .req_grant (req_grant),
    .req_done  (req_done),
    .req_err   (req_err),
    .owner     (owner),
    .busy      (busy),
    .sd_lba    (sd_lba),
    .sd_rd     (sd_rd),
    .sd_wr     (sd_wr),
    .sd_ack    (sd_ack)
  );

  always #5 clk_sys = ~clk_sys;

  // Returns at the first falling edge where a read or write strobe is visible.
  task automatic wait_issue(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk_sys);
      if (sd_rd || sd_wr) ok = 1'b1;
    end
  endtask

  // Host side: raise ack after dly cycles, hold len cycles, then drop it.
  task automatic host_ack(input int dly, input int len);
    repeat (dly) @(negedge clk_sys);
    sd_ack = 1'b1;
    repeat (len) @(negedge clk_sys);
    sd_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; req_we = '0; req_lba = '0; sd_ack = 1'b0;
    repeat (2) @(negedge clk_sys);
    checks++; if (req_grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b want 00", req_grant); end
    checks++; if (req_done !== 2'b00 || req_err !== 1'b0) begin errors++; $display("FAIL rst_done: got %b/%b want 00/0", req_done, req_err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b want 1", busy); end
    checks++; if (sd_rd !== 1'b0 || sd_wr !== 1'b0 || sd_lba !== 32'h0 || owner !== 1'b0) begin
      errors++; $display("FAIL rst_port: rd=%b wr=%b lba=%h owner=%b want 0", sd_rd, sd_wr, sd_lba, owner);
    end
    reset = 1'b0;
    @(negedge clk_sys);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_sync_exit: busy=%b want 0", busy); end
  endtask

  task automatic test_single_read();
    exp_t e;
    req_valid = 2'b01; req_we = 2'b00; req_lba[31:0] = 32'h1234;
    exp_q.push_back('{idx: 0, we: 1'b0, lba: 32'h1234});
    @(negedge clk_sys);
    e = exp_q.pop_front();
    checks++; if (req_grant !== 2'b01 || owner !== 1'(e.idx)) begin errors++; $display("FAIL rd_grant: got %b/%0d want 01/%0d", req_grant, owner, e.idx); end
    checks++; if (sd_rd !== 1'b1 || sd_wr !== 1'b0) begin errors++; $display("FAIL rd_strobe: rd=%b wr=%b want 1/0", sd_rd, sd_wr); end
    checks++; if (sd_lba !== e.lba) begin errors++; $display("FAIL rd_lba: got %h want %h", sd_lba, e.lba); end
    repeat (3) @(negedge clk_sys);
    sd_ack = 1'b1;
    @(negedge clk_sys);
    checks++; if (sd_rd !== 1'b0) begin errors++; $display("FAIL rd_clear: rd=%b want 0", sd_rd); end
    repeat (2) @(negedge clk_sys);
    sd_ack = 1'b0;
    @(negedge clk_sys);
    checks++; if (req_done !== 2'b01 || req_err !== 1'b0 || req_grant !== 2'b00) begin
      errors++; $display("FAIL rd_done: done=%b err=%b grant=%b want 01/0/00", req_done, req_err, req_grant);
    end
    req_valid = 2'b00;
    @(negedge clk_sys);
    checks++; if (req_done !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL rd_done_pulse: done=%b busy=%b want 00/0", req_done, busy); end
  endtask

  task automatic test_contention();
    exp_t e;
    bit   ok;
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    req_valid = 2'b11; req_we = 2'b10; req_lba = {32'hB001, 32'hA000};
    for (int k = 0; k < 4; k++) exp_q.push_back('{idx: k % 2, we: (k % 2) == 1, lba: (k % 2) ? 32'hB001 : 32'hA000});
    for (int k = 0; k < 4; k++) begin
      wait_issue(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL cont_issue%0d: no strobe within bound", k); end
      e = exp_q.pop_front();
      checks++; if (req_grant !== (2'b01 << e.idx) || owner !== 1'(e.idx)) begin
        errors++; $display("FAIL cont_grant%0d: got %b/%0d want idx %0d", k, req_grant, owner, e.idx);
      end
      checks++; if (sd_wr !== e.we || sd_rd !== !e.we || sd_lba !== e.lba) begin
        errors++; $display("FAIL cont_port%0d: rd=%b wr=%b lba=%h want we=%b lba=%h", k, sd_rd, sd_wr, sd_lba, e.we, e.lba);
      end
      host_ack(1, 2);
      @(negedge clk_sys);
      checks++; if (req_done !== (2'b01 << e.idx)) begin errors++; $display("FAIL cont_done%0d: got %b want idx %0d", k, req_done, e.idx); end
    end
    req_valid = 2'b00;
    @(negedge clk_sys);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_lba_stable();
    exp_t e;
    bit   ok;
    req_valid = 2'b01; req_we = 2'b00; req_lba[31:0] = 32'h5555;
    exp_q.push_back('{idx: 0, we: 1'b0, lba: 32'h5555});
    wait_issue(ok);
    e = exp_q.pop_front();
    checks++; if (ok !== 1'b1 || sd_lba !== e.lba) begin errors++; $display("FAIL lba_issue: ok=%b lba=%h want %h", ok, sd_lba, e.lba); end
    req_lba[31:0] = 32'hFFFF; req_we = 2'b01;
    repeat (2) @(negedge clk_sys);
    checks++; if (sd_lba !== e.lba || sd_rd !== 1'b1 || sd_wr !== 1'b0) begin
      errors++; $display("FAIL lba_hold: lba=%h rd=%b wr=%b want %h/1/0", sd_lba, sd_rd, sd_wr, e.lba);
    end
    host_ack(0, 3);
    @(negedge clk_sys);
    checks++; if (req_done !== 2'b01 || sd_lba !== e.lba) begin errors++; $display("FAIL lba_done: done=%b lba=%h want 01/%h", req_done, sd_lba, e.lba); end
    req_valid = 2'b00; req_we = 2'b00;
    @(negedge clk_sys);
  endtask

  task automatic test_timeout();
    exp_t e;
    bit   ok;
    int   early;
    req_valid = 2'b10; req_we = 2'b00; req_lba[63:32] = 32'h77;
    exp_q.push_back('{idx: 1, we: 1'b0, lba: 32'h77});
    wait_issue(ok);
    e = exp_q.pop_front();
    checks++; if (ok !== 1'b1 || req_grant !== 2'b10 || sd_lba !== e.lba) begin
      errors++; $display("FAIL to_issue: ok=%b grant=%b lba=%h want 1/10/%h", ok, req_grant, sd_lba, e.lba);
    end
    early = 0;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk_sys);
      if (sd_rd !== 1'b1 || req_done !== 2'b00) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL to_early: %0d cycles aborted early want 0", early); end
    @(negedge clk_sys);
    checks++; if (sd_rd !== 1'b0 || req_done !== 2'b10 || req_err !== 1'b1 || req_grant !== 2'b00) begin
      errors++; $display("FAIL to_abort: rd=%b done=%b err=%b grant=%b want 0/10/1/00", sd_rd, req_done, req_err, req_grant);
    end
    req_valid = 2'b00;
    @(negedge clk_sys);
    req_valid = 2'b01; req_lba[31:0] = 32'h99;
    exp_q.push_back('{idx: 0, we: 1'b0, lba: 32'h99});
    wait_issue(ok);
    e = exp_q.pop_front();
    checks++; if (ok !== 1'b1 || req_grant !== 2'b01 || sd_lba !== e.lba) begin
      errors++; $display("FAIL to_next: ok=%b grant=%b lba=%h want 1/01/%h", ok, req_grant, sd_lba, e.lba);
    end
    host_ack(1, 1);
    @(negedge clk_sys);
    checks++; if (req_done !== 2'b01 || req_err !== 1'b0) begin errors++; $display("FAIL to_next_done: done=%b err=%b want 01/0", req_done, req_err); end
    req_valid = 2'b00;
    @(negedge clk_sys);
  endtask

  task automatic test_reset_xfer();
    exp_t e;
    bit   ok;
    req_valid = 2'b01; req_we = 2'b00; req_lba[31:0] = 32'h42;
    exp_q.push_back('{idx: 0, we: 1'b0, lba: 32'h42});
    wait_issue(ok);
    e = exp_q.pop_front();
    checks++; if (ok !== 1'b1 || sd_lba !== e.lba) begin errors++; $display("FAIL rx_issue: ok=%b lba=%h want 1/%h", ok, sd_lba, e.lba); end
    sd_ack = 1'b1;
    @(negedge clk_sys);
    reset = 1'b1;
    #1;
    checks++; if (req_grant !== 2'b00 || req_done !== 2'b00 || sd_rd !== 1'b0 || busy !== 1'b1 || sd_lba !== 32'h0) begin
      errors++; $display("FAIL rx_reset: grant=%b done=%b rd=%b busy=%b lba=%h want 00/00/0/1/0", req_grant, req_done, sd_rd, busy, sd_lba);
    end
    @(negedge clk_sys);
    reset = 1'b0;
    exp_q.push_back('{idx: 0, we: 1'b0, lba: 32'h42});
    repeat (3) @(negedge clk_sys);
    checks++; if (req_grant !== 2'b00 || busy !== 1'b1 || sd_rd !== 1'b0) begin
      errors++; $display("FAIL rx_sync_hold: grant=%b busy=%b rd=%b want 00/1/0", req_grant, busy, sd_rd);
    end
    sd_ack = 1'b0;
    repeat (2) @(negedge clk_sys);
    e = exp_q.pop_front();
    checks++; if (req_grant !== 2'b01 || sd_rd !== 1'b1 || sd_lba !== e.lba) begin
      errors++; $display("FAIL rx_regrant: grant=%b rd=%b lba=%h want 01/1/%h", req_grant, sd_rd, sd_lba, e.lba);
    end
    host_ack(1, 1);
    @(negedge clk_sys);
    checks++; if (req_done !== 2'b01) begin errors++; $display("FAIL rx_done: done=%b want 01", req_done); end
    req_valid = 2'b00;
    @(negedge clk_sys);
  endtask

  task automatic test_valid_drop();
    exp_t e;
    bit   ok;
    int   extra;
    req_valid = 2'b10; req_we = 2'b10; req_lba[63:32] = 32'h321;
    exp_q.push_back('{idx: 1, we: 1'b1, lba: 32'h321});
    wait_issue(ok);
    e = exp_q.pop_front();
    checks++; if (ok !== 1'b1 || sd_wr !== 1'b1 || sd_rd !== 1'b0 || sd_lba !== e.lba) begin
      errors++; $display("FAIL vd_issue: ok=%b wr=%b rd=%b lba=%h want 1/1/0/%h", ok, sd_wr, sd_rd, sd_lba, e.lba);
    end
    req_valid = 2'b00;
    host_ack(1, 1);
    @(negedge clk_sys);
    checks++; if (req_done !== 2'b10) begin errors++; $display("FAIL vd_done: done=%b want 10", req_done); end
    extra = 0;
    repeat (5) begin
      @(negedge clk_sys);
      if (sd_rd || sd_wr || req_grant !== 2'b00) extra++;
    end
    checks++; if (extra !== 0 || busy !== 1'b0) begin errors++; $display("FAIL vd_no_repeat: %0d busy cycles, busy=%b want 0/0", extra, busy); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   ok;
    req_valid = 2'b01; req_we = 2'b01; req_lba[31:0] = 32'hC0DE;
    repeat (2) exp_q.push_back('{idx: 0, we: 1'b1, lba: 32'hC0DE});
    for (int k = 0; k < 2; k++) begin
      wait_issue(ok);
      e = exp_q.pop_front();
      checks++; if (ok !== 1'b1 || req_grant !== 2'b01 || sd_wr !== e.we || sd_lba !== e.lba) begin
        errors++; $display("FAIL b2b_issue%0d: ok=%b grant=%b wr=%b lba=%h want 1/01/%b/%h", k, ok, req_grant, sd_wr, sd_lba, e.we, e.lba);
      end
      host_ack(0, 1);
      @(negedge clk_sys);
      checks++; if (req_done !== 2'b01) begin errors++; $display("FAIL b2b_done%0d: done=%b want 01", k, req_done); end
    end
    req_valid = 2'b00;
    @(negedge clk_sys);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_lba_stable();
    test_timeout();
    test_reset_xfer();
    test_valid_drop();
    test_back_to_back();
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL sb_empty: %0d expected transactions left want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
